// File: rtl/ifetch_if.sv
// Fetch-stage bus: memory-controller refill channel plus the registered bundle to the decoder.
// master = fetch stage, slave = memory controller / decoder side.
interface ifetch_if;
  logic        mc_en;
  logic [31:0] mc_pc;
  logic        mc_done;
  logic [31:0] mc_data;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pre_jump;

  modport master (
    output mc_en, mc_pc, inst_rdy, inst, inst_pc, inst_pre_jump,
    input  mc_done, mc_data
  );

  modport slave (
    input  mc_en, mc_pc, inst_rdy, inst, inst_pc, inst_pre_jump,
    output mc_done, mc_data
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: direct-mapped one-word-per-line icache with miss refill, BHT-based
// next-PC prediction, rollback redirect and commit-time BHT training.
module ifetch #(
  parameter int unsigned ICACHE_IDX_W = 6,
  parameter int unsigned BHT_IDX_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rob_full,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        br_upd,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_jump,
  ifetch_if.master    bus
);

  localparam int unsigned IcacheN = 1 << ICACHE_IDX_W;
  localparam int unsigned BhtN    = 1 << BHT_IDX_W;
  localparam int unsigned TagW    = 32 - ICACHE_IDX_W - 2;

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e      state_q;
  logic [31:0] pc_q;

  logic [IcacheN-1:0] cache_valid_q;
  logic [TagW-1:0]    cache_tag_q  [IcacheN];
  logic [31:0]        cache_data_q [IcacheN];
  logic [1:0]         bht_q        [BhtN];

  logic [ICACHE_IDX_W-1:0] c_idx;
  logic [TagW-1:0]         c_tag;
  logic [BHT_IDX_W-1:0]    p_idx;
  logic [BHT_IDX_W-1:0]    u_idx;
  logic                    hit;
  logic [31:0]             word;
  logic [31:0]             imm_j;
  logic [31:0]             imm_b;
  logic                    taken;
  logic [31:0]             next_pc;
  logic                    stall;
  logic                    fill_we;
  logic                    unused_br_pc;

  assign unused_br_pc = ^{br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0]};

  always_comb begin
    c_idx   = pc_q[ICACHE_IDX_W+1:2];
    c_tag   = pc_q[31:ICACHE_IDX_W+2];
    p_idx   = pc_q[BHT_IDX_W+1:2];
    u_idx   = br_upd_pc[BHT_IDX_W+1:2];
    hit     = cache_valid_q[c_idx] && (cache_tag_q[c_idx] == c_tag);
    word    = cache_data_q[c_idx];
    imm_j   = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    imm_b   = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    taken   = 1'b0;
    next_pc = pc_q + 32'd4;
    // Prediction reads the BHT before this cycle's training write lands.
    if (word[6:0] == OpJal) begin
      taken   = 1'b1;
      next_pc = pc_q + imm_j;
    end else if (word[6:0] == OpBranch && bht_q[p_idx] >= 2'd2) begin
      taken   = 1'b1;
      next_pc = pc_q + imm_b;
    end
    stall   = rs_full | lsb_full | rob_full;
    fill_we = rdy && !rollback && (state_q == StWaitMem) && bus.mc_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      pc_q              <= '0;
      bus.inst_rdy      <= 1'b0;
      bus.inst          <= '0;
      bus.inst_pc       <= '0;
      bus.inst_pre_jump <= 1'b0;
      bus.mc_en         <= 1'b0;
      bus.mc_pc         <= '0;
    end else if (rdy) begin
      if (rollback) begin
        // An mc_done arriving now is dropped; fill_we is also gated by rollback.
        pc_q         <= rollback_pc;
        bus.inst_rdy <= 1'b0;
        bus.mc_en    <= 1'b0;
        state_q      <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!hit) begin
              // Miss starts even under stall so the refill overlaps it.
              bus.mc_en    <= 1'b1;
              bus.mc_pc    <= {pc_q[31:2], 2'b00};
              bus.inst_rdy <= 1'b0;
              state_q      <= StWaitMem;
            end else if (stall) begin
              bus.inst_rdy <= 1'b0;
            end else begin
              bus.inst          <= word;
              bus.inst_pc       <= pc_q;
              bus.inst_pre_jump <= taken;
              bus.inst_rdy      <= 1'b1;
              pc_q              <= next_pc;
            end
          end
          StWaitMem: begin
            bus.inst_rdy <= 1'b0;
            if (bus.mc_done) begin
              bus.mc_en <= 1'b0;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= '0;
    end else if (fill_we) begin
      cache_valid_q[c_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      cache_tag_q[c_idx]  <= c_tag;
      cache_data_q[c_idx] <= bus.mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BhtN; i++) begin
        bht_q[i] <= 2'd1;
      end
    end else if (rdy && br_upd) begin
      if (br_upd_jump) begin
        if (bht_q[u_idx] != 2'd3) bht_q[u_idx] <= bht_q[u_idx] + 2'd1;
      end else begin
        if (bht_q[u_idx] != 2'd0) bht_q[u_idx] <= bht_q[u_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cold miss, warm loop, branch prediction/training, stall,
// rollback during a refill, reset during a refill and global-enable hold.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rs_full;
  logic        lsb_full;
  logic        rob_full;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        br_upd;
  logic [31:0] br_upd_pc;
  logic        br_upd_jump;

  ifetch_if bus ();

  ifetch #(
    .ICACHE_IDX_W(6),
    .BHT_IDX_W   (8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rs_full    (rs_full),
    .lsb_full   (lsb_full),
    .rob_full   (rob_full),
    .rollback   (rollback),
    .rollback_pc(rollback_pc),
    .br_upd     (br_upd),
    .br_upd_pc  (br_upd_pc),
    .br_upd_jump(br_upd_jump),
    .bus        (bus.master)
  );

  localparam logic [31:0] Addi = 32'h0050_0093;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Beq  = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] Jal  = 32'h1000_006F;  // jal x0,+0x100

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mc(input string tag, input logic [31:0] exp_pc);
    int i = 0;
    while (bus.mc_en !== 1'b1 && i < 20) begin
      step();
      i++;
    end
    check({tag, "_mc_en"}, {31'd0, bus.mc_en}, 32'd1);
    check({tag, "_mc_pc"}, bus.mc_pc, exp_pc);
  endtask

  // Serve one refill with a 3-cycle memory latency.
  task automatic fill(input string tag, input logic [31:0] exp_pc, input logic [31:0] data);
    wait_mc(tag, exp_pc);
    step();
    step();
    bus.mc_done = 1'b1;
    bus.mc_data = data;
    step();
    bus.mc_done = 1'b0;
    bus.mc_data = '0;
    check({tag, "_mc_en_drop"}, {31'd0, bus.mc_en}, 32'd0);
    check({tag, "_no_bypass"}, {31'd0, bus.inst_rdy}, 32'd0);
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] pc, input logic pj);
    check({tag, "_rdy"}, {31'd0, bus.inst_rdy}, 32'd1);
    check({tag, "_pc"}, bus.inst_pc, pc);
    check({tag, "_pj"}, {31'd0, bus.inst_pre_jump}, {31'd0, pj});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rs_full = 1'b0; lsb_full = 1'b0; rob_full = 1'b0;
    rollback = 1'b0; rollback_pc = '0; br_upd = 1'b0; br_upd_pc = '0; br_upd_jump = 1'b0;
    bus.mc_done = 1'b0; bus.mc_data = '0;
    step();
    step();
    check("rst_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    check("rst_mc_en", {31'd0, bus.mc_en}, 32'd0);
    check("rst_mc_pc", bus.mc_pc, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_pj", {31'd0, bus.inst_pre_jump}, 32'd0);
    rst = 1'b0;

    // Cold fetch and straight-line fill of 0..0x14.
    fill("cold", 32'h0, Addi);
    step();
    expect_inst("cold", 32'h0, 1'b0);
    check("cold_inst", bus.inst, Addi);
    fill("f4", 32'h4, Nop);
    step();
    expect_inst("f4", 32'h4, 1'b0);
    fill("f8", 32'h8, Nop);
    step();
    fill("fc", 32'hC, Nop);
    step();
    expect_inst("fc", 32'hC, 1'b0);
    fill("f10", 32'h10, Beq);
    step();
    expect_inst("beq_cold", 32'h10, 1'b0);
    fill("f14", 32'h14, Nop);
    step();
    expect_inst("f14", 32'h14, 1'b0);

    // Rollback to 0 while 0x18 misses; train the BHT for 0x10 during the warm loop.
    rollback = 1'b1; rollback_pc = 32'h0;
    step();
    rollback = 1'b0;
    check("rb_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    check("rb_mc_en", {31'd0, bus.mc_en}, 32'd0);
    br_upd = 1'b1; br_upd_pc = 32'h10; br_upd_jump = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_inst("loop", 32'(k * 4), 1'b0);
      check("loop_no_mc", {31'd0, bus.mc_en}, 32'd0);
      if (k == 1) br_upd = 1'b0;
    end
    step();
    expect_inst("beq_taken", 32'h10, 1'b1);
    check("beq_inst", bus.inst, Beq);
    step();
    expect_inst("beq_target", 32'h8, 1'b0);

    // Stall for 5 cycles while 0xC is being looked up.
    rob_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_no_rdy", {31'd0, bus.inst_rdy}, 32'd0);
      check("stall_no_mc", {31'd0, bus.mc_en}, 32'd0);
    end
    rob_full = 1'b0;
    step();
    expect_inst("stall_resume", 32'hC, 1'b0);

    // JAL prediction.
    rollback = 1'b1; rollback_pc = 32'h20;
    step();
    rollback = 1'b0;
    check("rb20_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    fill("f20", 32'h20, Jal);
    step();
    expect_inst("jal", 32'h20, 1'b1);
    wait_mc("jal_target", 32'h120);

    // Rollback with a coincident mc_done: the fill of 0x120 must be dropped.
    rollback = 1'b1; rollback_pc = 32'h200;
    bus.mc_done = 1'b1; bus.mc_data = Nop;
    step();
    rollback = 1'b0;
    bus.mc_done = 1'b0;
    check("rbmid_mc_en", {31'd0, bus.mc_en}, 32'd0);
    check("rbmid_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    wait_mc("rbmid_new", 32'h200);
    rollback = 1'b1; rollback_pc = 32'h120;
    step();
    rollback = 1'b0;
    wait_mc("refetch_miss", 32'h120);

    // Reset while waiting on memory.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_mc_en", {31'd0, bus.mc_en}, 32'd0);
    check("rstmid_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    check("rstmid_inst_pc", bus.inst_pc, 32'd0);
    fill("post_rst", 32'h0, Addi);
    step();
    expect_inst("post_rst", 32'h0, 1'b0);

    // Global enable low: outputs hold, including the inst_rdy pulse.
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_rdy", {31'd0, bus.inst_rdy}, 32'd1);
      check("hold_pc", bus.inst_pc, 32'h0);
      check("hold_mc_en", {31'd0, bus.mc_en}, 32'd0);
    end
    rdy = 1'b1;
    step();
    check("resume_rdy", {31'd0, bus.inst_rdy}, 32'd0);
    check("resume_mc_en", {31'd0, bus.mc_en}, 32'd1);
    check("resume_mc_pc", bus.mc_pc, 32'h4);

    // BHT was reset to weakly-not-taken.
    rollback = 1'b1; rollback_pc = 32'h10;
    step();
    rollback = 1'b0;
    fill("f10_rst", 32'h10, Beq);
    step();
    expect_inst("beq_after_rst", 32'h10, 1'b0);
    wait_mc("beq_after_rst_next", 32'h14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage, directly upstream of the decoder. Holds the architectural fetch PC, looks it up in a direct-mapped instruction cache, and fills misses through the memory controller. Predicts the next PC with a BHT of 2-bit counters. Hands one instruction per cycle to the decoder as a registered `inst_rdy` / `inst` / `inst_pc` / `inst_pre_jump` bundle. Redirects on ROB rollback and trains the BHT from committed branches.

## Interface
- `ICACHE_IDX_W`, 6: log2 of icache entries; each entry holds one 32-bit word.
- `BHT_IDX_W`, 8: log2 of BHT entries; index is `pc[BHT_IDX_W+1:2]`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; when low, all state, including outputs, holds.
- `rs_full`, `lsb_full`, `rob_full`  in  1 each  downstream full, asserted with one-slot margin.
- `rollback`  in  1  mispredict or flush from ROB.
- `rollback_pc`  in  32  redirect target.
- `br_upd`  in  1  committed conditional branch this cycle.
- `br_upd_pc`  in  32  PC of the committed branch.
- `br_upd_jump`  in  1  actual outcome of the committed branch.
- `mc_en`  out  1  fetch request to the memory controller; held high until done.
- `mc_pc`  out  32  word-aligned fetch address.
- `mc_done`  in  1  one-cycle pulse; `mc_data` is valid.
- `mc_data`  in  32  fetched word.
- `inst_rdy`  out  1  instruction valid for the decoder, one-cycle pulse per instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  instruction PC.
- `inst_pre_jump`  out  1  predicted taken.

## Operation
- States: IDLE and WAIT_MEM.
- Stall is `rs_full | lsb_full | rob_full`.
- Icache entry fields: valid, tag = `pc[31:ICACHE_IDX_W+2]`, data. Index is `pc[ICACHE_IDX_W+1:2]`.
- Hit is when the entry at `pc`'s index is valid and its tag matches.
- IDLE, hit, no stall:
  - Register `inst`, `inst_pc = pc`, `inst_pre_jump`.
  - Assert `inst_rdy` and set `pc <= next_pc`.
- IDLE, hit, stall: `inst_rdy <= 0`; `pc` holds.
- IDLE, miss: `mc_en <= 1`, `mc_pc <= pc`, go to WAIT_MEM; `inst_rdy <= 0`.
  - A miss starts regardless of stall, so the fill overlaps the stall.
- WAIT_MEM, `mc_done`: write the entry (valid=1, tag, data), `mc_en <= 0`, go to IDLE.
  - The instruction issues on the following IDLE-hit cycle; there is no bypass.
- Prediction is decoded from the cached word (opcode is bits 6:0):
  - JAL (1101111): taken; `next_pc = pc + J-imm`, where J-imm is sign-extended `{i[31],i[19:12],i[20],i[30:21],0}`.
  - B (1100011): taken iff BHT counter is ≥ 2; target is `pc + B-imm`, where B-imm is sign-extended `{i[31],i[7],i[30:25],i[11:8],0}`. Otherwise `pc+4`.
  - All other opcodes, including JALR: not taken; `next_pc = pc+4`.
  - `inst_pre_jump` = taken.
- BHT update on `br_upd`: the counter at `br_upd_pc`'s index saturates up if `br_upd_jump`, down otherwise (range 0..3).
- Rollback has priority over everything except `rst`:
  - `pc <= rollback_pc`, `inst_rdy <= 0`, `mc_en <= 0`, state becomes IDLE.
  - A `mc_done` in the same cycle is discarded; no cache write.
  - Memory controller contract: dropping `mc_en` aborts the request, and `mc_done` never fires while `mc_en` is low.
- Cache and BHT contents survive rollback.
- Arithmetic is 32-bit and wraps modulo 2^32; the PC carry-out is discarded.

## Timing
- Reset values:
  - `pc = 0`, state IDLE.
  - `inst_rdy`, `inst`, `inst_pc`, `inst_pre_jump`, `mc_en`, `mc_pc` = 0.
  - All icache valid bits = 0; all BHT counters = 1 (weakly not taken).
- Hit latency: instruction visible one cycle after PC presentation; throughput one instruction per cycle on consecutive hits.
- Miss latency: `mc_en` rises 1 cycle after the miss is seen. The fill is written on the `mc_done` cycle. `inst_rdy` rises 2 cycles after `mc_done`.
- Stall seen in cycle N: no `inst_rdy` in cycle N+1. Downstream's one-slot margin absorbs the instruction already issued.
- Rollback in cycle N: `inst_rdy` is 0 in N+1. The first lookup of `rollback_pc` is in N+1, so on a hit the instruction is out in N+2.
- BHT update and prediction on the same index in the same cycle: prediction uses the pre-update counter.
- `rst` asserted mid-WAIT_MEM: `mc_en` is 0 the next cycle and all state is at reset values.
- `rdy` low: nothing changes; `mc_en` stays at its value.

## Test plan
- **Cold fetch:** reset, memory returns `addi x1,x0,5` (0x00500093) at PC 0 after 3 cycles -> `mc_en` high with `mc_pc = 0`; `inst_rdy` with `inst = 0x00500093`, `inst_pc = 0`, `inst_pre_jump = 0` two cycles after `mc_done`; PC becomes 4.
- **Loop, hits:** warm straight-line code at 0..12, refetch after rollback to 0 -> four back-to-back `inst_rdy` pulses with `inst_pc` 0, 4, 8, 12 and no `mc_en`.
- **Branch prediction:** at PC 0x10, `beq` with imm -8, counter initially 1 -> `pre_jump = 0`, next PC 0x14. After two `br_upd` with taken and `br_upd_pc = 0x10`, a refetch gives `pre_jump = 1` and next PC 0x08. JAL +0x100 at 0x20 -> next PC 0x120.
- **Stall:** `rob_full` held for 5 cycles during hit streaming -> no `inst_rdy` during the stall; PC unchanged; resumes with the same `inst_pc` one cycle after release.
- **Rollback mid-miss:** rollback to 0x200 while in WAIT_MEM, with `mc_done` in the same cycle -> no cache write (a later refetch of the old PC misses); next `mc_pc = 0x200`.
- **Reset during miss:** `rst` in WAIT_MEM -> next cycle `mc_en = 0`, `pc = 0`, all entries invalid, `inst_rdy = 0`.
